// File: rtl/pll_sup_pkg.sv
// Shared types, 27 MHz timing defaults and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 27000;
  localparam int unsigned DEF_STABLE_CYCLES = 2700;
  localparam int unsigned DEF_CNT_W         = 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; 2-cycle latency, no backpressure.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives rPLL RESET, waits for lock with timeout/retry, qualifies lock before pll_ok_o; no backpressure.
// Optional saturating stats counters built only with PLL_SUP_STATS_EN defined.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pll_lock_i,
  output logic             pll_reset_o,
  output logic             pll_ok_o,
  output logic             lock_fail_o,
  output logic [CNT_W-1:0] retry_cnt_o,
  output logic [CNT_W-1:0] lost_cnt_o
);

  localparam int unsigned T_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned TW    = (clog2(T_MAX) < 1) ? 1 : clog2(T_MAX);

  localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);

  pll_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          lock_s;
  logic          fail_d;

  sync_2ff u_lock_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (pll_lock_i),
    .q     (lock_s)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    fail_d  = 1'b0;
    case (state_q)
      PLL_RST: begin
        if (timer_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // lock takes priority over a timeout landing on the same cycle
        if (lock_s) begin
          state_d = STABLE;
        end else if (timer_q == TO_LAST) begin
          state_d = PLL_RST;
          fail_d  = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) state_d = WAIT_LOCK;
        else if (timer_q == STABLE_LAST) state_d = RUN;
      end
      RUN: begin
        timer_d = timer_q;
        if (!lock_s) state_d = PLL_RST;
      end
      default: state_d = PLL_RST;
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  // Outputs are registered from the next state so they change on the transition edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= PLL_RST;
      timer_q     <= '0;
      pll_reset_o <= 1'b1;
      pll_ok_o    <= 1'b0;
      lock_fail_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pll_reset_o <= (state_d == PLL_RST);
      pll_ok_o    <= (state_d == RUN);
      lock_fail_o <= fail_d;
    end
  end

`ifdef PLL_SUP_STATS_EN
  logic [CNT_W-1:0] retry_q, lost_q;
  logic             lost_evt;

  assign lost_evt = (state_q == RUN) && !lock_s;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      retry_q <= '0;
      lost_q  <= '0;
    end else begin
      if (fail_d && (retry_q != {CNT_W{1'b1}})) retry_q <= retry_q + CNT_W'(1);
      if (lost_evt && (lost_q != {CNT_W{1'b1}})) lost_q <= lost_q + CNT_W'(1);
    end
  end

  assign retry_cnt_o = retry_q;
  assign lost_cnt_o  = lost_q;
`else
  assign retry_cnt_o = '0;
  assign lost_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with shortened timing; expectations follow PLL_SUP_STATS_EN.
module tb_pll_lock_supervisor;

  localparam int RST_C = 4;
  localparam int TO_C  = 20;
  localparam int ST_C  = 8;
  localparam int CW    = 2;
`ifdef PLL_SUP_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  localparam int SEL_RST  = 0;
  localparam int SEL_OK   = 1;
  localparam int SEL_FAIL = 2;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b1;
  logic          pll_lock_i = 1'b0;
  logic          pll_reset_o, pll_ok_o, lock_fail_o;
  logic [CW-1:0] retry_cnt_o, lost_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  pll_lock_supervisor #(
    .RST_CYCLES    (RST_C),
    .LOCK_TIMEOUT  (TO_C),
    .STABLE_CYCLES (ST_C),
    .CNT_W         (CW)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .pll_lock_i  (pll_lock_i),
    .pll_reset_o (pll_reset_o),
    .pll_ok_o    (pll_ok_o),
    .lock_fail_o (lock_fail_o),
    .retry_cnt_o (retry_cnt_o),
    .lost_cnt_o  (lost_cnt_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge sys_clk);
  endtask

  function automatic logic sel(input int w);
    case (w)
      SEL_RST: return pll_reset_o;
      SEL_OK:  return pll_ok_o;
      default: return lock_fail_o;
    endcase
  endfunction

  // Counts rising sys_clk edges until the selected output reads val; saturates at bound.
  task automatic wait_for(input int w, input logic val, input int bound, output int n);
    n = 0;
    while (sel(w) !== val && n < bound) begin
      @(negedge sys_clk);
      n++;
    end
  endtask

  task automatic do_reset(input logic lock_val);
    @(negedge sys_clk);
    pll_lock_i = lock_val;
    sys_rst_n  = 1'b0;
    step(2);
    sys_rst_n = 1'b1;
  endtask

  function automatic int sat(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  initial begin
    int n;
    int bad;

    // Reset values
    do_reset(1'b0);
    sys_rst_n = 1'b0;
    #1;
    chk("rst_pll_reset", pll_reset_o, 1);
    chk("rst_pll_ok", pll_ok_o, 0);
    chk("rst_lock_fail", lock_fail_o, 0);
    chk("rst_retry", retry_cnt_o, 0);
    chk("rst_lost", lost_cnt_o, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // 1: reset held RST_C cycles; lock 5 cycles after release of PLL reset
    wait_for(SEL_RST, 1'b0, 50, n);
    chk("t1_reset_len", n, RST_C);
    step(4);
    pll_lock_i = 1'b1;
    // 2 sync edges + 8 STABLE edges + 1 transition edge into RUN
    wait_for(SEL_OK, 1'b1, 50, n);
    chk("t1_ok_delay", n, 2 + ST_C + 1);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (pll_ok_o !== 1'b1 || pll_reset_o !== 1'b0 || lock_fail_o !== 1'b0) bad++;
    end
    chk("t1_run_hold", bad, 0);
    chk("t1_retry", retry_cnt_o, 0);

    // 4: lock loss in RUN
    pll_lock_i = 1'b0;
    wait_for(SEL_OK, 1'b0, 20, n);
    chk("t4_ok_fall", n, 2 + 1);
    chk("t4_pll_reset", pll_reset_o, 1);
    chk("t4_lost", lost_cnt_o, STATS);
    pll_lock_i = 1'b1;
    wait_for(SEL_RST, 1'b0, 20, n);
    chk("t4_reset_len", n, RST_C);
    // lock_s already high: one edge into STABLE, then 8 qualification edges
    wait_for(SEL_OK, 1'b1, 30, n);
    chk("t4_rerun", n, 1 + ST_C);
    chk("t4_retry", retry_cnt_o, 0);

    // 3: one-cycle glitch after 5 good STABLE cycles
    do_reset(1'b0);
    wait_for(SEL_RST, 1'b0, 50, n);
    chk("t3_reset_len", n, RST_C);
    pll_lock_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (pll_ok_o !== 1'b0) bad++;
    end
    pll_lock_i = 1'b0;
    step(1);
    if (pll_ok_o !== 1'b0) bad++;
    pll_lock_i = 1'b1;
    wait_for(SEL_OK, 1'b1, 40, n);
    chk("t3_no_early_ok", bad, 0);
    chk("t3_ok_delay", n, 2 + ST_C + 1);
    chk("t3_retry", retry_cnt_o, 0);
    chk("t3_lost", lost_cnt_o, 0);

    // 5: async reset mid-STABLE
    do_reset(1'b1);
    wait_for(SEL_RST, 1'b0, 50, n);
    step(4);
    chk("t5_pre_ok", pll_ok_o, 0);
    chk("t5_pre_reset", pll_reset_o, 0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("t5_async_reset", pll_reset_o, 1);
    chk("t5_async_ok", pll_ok_o, 0);
    chk("t5_async_fail", lock_fail_o, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_for(SEL_RST, 1'b0, 50, n);
    chk("t5_rereset_len", n, RST_C);
    wait_for(SEL_OK, 1'b1, 30, n);
    chk("t5_rerun", n, 1 + ST_C);

    // 2: lock never asserts -> timeout every RST_C + TO_C cycles
    do_reset(1'b0);
    wait_for(SEL_FAIL, 1'b1, 60, n);
    chk("t2_first_fail", n, RST_C + TO_C);
    chk("t2_retry_1", retry_cnt_o, STATS * 1);
    for (int k = 2; k <= 4; k++) begin
      wait_for(SEL_FAIL, 1'b0, 60, n);
      chk("t2_pulse_width", n, 1);
      wait_for(SEL_FAIL, 1'b1, 60, n);
      chk("t2_period", n + 1, RST_C + TO_C);
      chk("t2_retry_sat", retry_cnt_o, STATS * sat(k));
    end
    chk("t2_ok_low", pll_ok_o, 0);
    chk("t2_lost", lost_cnt_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
